// File: rtl/moto_display_pkg.sv
// Shared encodings for the dashboard RPM display: 7-segment digit patterns,
// converter state encoding and scan digit-index sizing.
package moto_display_pkg;

    localparam int BCD_W      = 12;
    localparam int DIGIT_W    = 2;
    localparam int NUM_DIGITS = 3;

    // Active-high patterns, bit0=a .. bit6=g.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts an 8-bit binary value to three BCD digits
// in 8 SHIFT cycles, publishing the result with a one-cycle valid pulse.
module bin2bcd_seq
    import moto_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  data,
    output logic [11:0] bcd,
    output logic        valid,
    output logic        state_dbg
);

    // Handshake: start is taken only while IDLE (state_dbg==0) and is ignored
    // during SHIFT; valid is high for exactly the one cycle after bcd updates.
    conv_state_t state, state_next;
    logic [19:0] sh, sh_next, adj;
    logic [2:0]  iter, iter_next;
    logic [11:0] bcd_next;
    logic        valid_next;
    logic        unused_msb;

    assign state_dbg  = state;
    assign unused_msb = adj[19];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CONV_IDLE;
            sh    <= '0;
            iter  <= '0;
            bcd   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            sh    <= sh_next;
            iter  <= iter_next;
            bcd   <= bcd_next;
            valid <= valid_next;
        end
    end

    always_comb begin
        adj        = sh;
        state_next = state;
        sh_next    = sh;
        iter_next  = iter;
        bcd_next   = bcd;
        valid_next = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sh[8+4*i +: 4] >= 4'd5) adj[8+4*i +: 4] = sh[8+4*i +: 4] + 4'd3;
        end
        case (state)
            CONV_IDLE: begin
                if (start) begin
                    sh_next    = {12'b0, data};
                    iter_next  = '0;
                    state_next = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                sh_next   = {adj[18:0], 1'b0};
                iter_next = iter + 3'd1;
                if (iter == 3'd7) begin
                    bcd_next   = sh_next[19:8];
                    valid_next = 1'b1;
                    state_next = CONV_IDLE;
                end
            end
            default: state_next = CONV_IDLE;
        endcase
    end

endmodule

// File: rtl/rpm_display.sv
// Dashboard RPM readout: converts data_RPM to BCD on change and scans three
// multiplexed 7-segment digits with leading-zero blanking.
module rpm_display
    import moto_display_pkg::*;
#(
    parameter int B              = 7,
    parameter int REFRESH_CNT    = 50000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [B:0]   data_RPM,
    output logic [6:0]   seg,
    output logic [2:0]   an,
    output logic [11:0]  bcd,
    output logic         bcd_valid
);

    localparam int   CNT_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam logic POL   = (SEG_ACTIVE_LOW != 0);

    logic [B:0]         last_val;
    logic               conv_busy, conv_start;
    logic [CNT_W-1:0]   refresh_cnt;
    logic [DIGIT_W-1:0] digit_idx;
    logic               terminal, blank;
    logic [3:0]         slot_nib;
    logic [2:0]         an_raw;
    logic [6:0]         seg_raw;

    // A change arriving mid-conversion stays pending until the engine is idle.
    assign conv_start = (data_RPM != last_val) && !conv_busy;

    bin2bcd_seq u_conv (
        .clk       (clk),
        .reset     (reset),
        .start     (conv_start),
        .data      (data_RPM),
        .bcd       (bcd),
        .valid     (bcd_valid),
        .state_dbg (conv_busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_val <= '0;
        else if (conv_start) last_val <= data_RPM;
    end

    assign terminal = (refresh_cnt == CNT_W'(REFRESH_CNT - 1));

    always_comb begin
        an_raw   = 3'b001;
        slot_nib = bcd[3:0];
        blank    = 1'b0;
        case (digit_idx)
            2'd1: begin
                an_raw   = 3'b010;
                slot_nib = bcd[7:4];
                blank    = (bcd[11:4] == 8'd0);
            end
            2'd2: begin
                an_raw   = 3'b100;
                slot_nib = bcd[11:8];
                blank    = (bcd[11:8] == 4'd0);
            end
            default: ;
        endcase
        seg_raw = blank ? SEG_BLANK : seg_decode(slot_nib);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an          <= {3{POL}};
            seg         <= {7{POL}};
        end else if (terminal) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            an          <= an_raw ^ {3{POL}};
            seg         <= seg_raw ^ {7{POL}};
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

endmodule
